// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcode patterns and control codes for the LEGv8 multicycle sequencer
package multicycle_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_LDUR,
      CLS_STUR,
      CLS_CBZ,
      CLS_B,
      CLS_MOVZ,
      CLS_ILLEGAL
   } op_class_e;

   localparam logic [10:0] OP_LDUR   = 11'b11111000010;
   localparam logic [10:0] OP_STUR   = 11'b11111000000;
   localparam logic [10:0] OP_ADD    = 11'b10001011000;
   localparam logic [10:0] OP_SUB    = 11'b11001011000;
   localparam logic [10:0] OP_AND    = 11'b10001010000;
   localparam logic [10:0] OP_ORR    = 11'b10101010000;
   localparam logic [10:0] OP_CBZ    = 11'b10110100000;
   localparam logic [10:0] OP_B      = 11'b00010100000;
   localparam logic [10:0] OP_MOVZ   = 11'b11010010100;
   localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
   localparam logic [10:0] MASK_B    = 11'b11111100000;
   localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

   localparam logic [3:0] ALUOP_AND   = 4'b0000;
   localparam logic [3:0] ALUOP_ORR   = 4'b0001;
   localparam logic [3:0] ALUOP_ADD   = 4'b0010;
   localparam logic [3:0] ALUOP_SUB   = 4'b0110;
   localparam logic [3:0] ALUOP_PASSB = 4'b0111;

   localparam logic [2:0] SIGNOP_R    = 3'b000;
   localparam logic [2:0] SIGNOP_D    = 3'b001;
   localparam logic [2:0] SIGNOP_B    = 3'b010;
   localparam logic [2:0] SIGNOP_CB   = 3'b011;
   localparam logic [2:0] SIGNOP_MOVZ = 3'b100;

   function automatic logic op_match(input logic [10:0] op, input logic [10:0] pattern,
                                     input logic [10:0] mask);
      return (op & mask) == pattern;
   endfunction

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode[31:21] to instruction class decode
module opcode_classifier
   import multicycle_pkg::*;
(
   input  logic [10:0] opcode,
   output op_class_e   op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      if (opcode == OP_LDUR) begin
         op_class = CLS_LDUR;
      end else if (opcode == OP_STUR) begin
         op_class = CLS_STUR;
      end else if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
         op_class = CLS_R;
      end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
         op_class = CLS_CBZ;
      end else if (op_match(opcode, OP_B, MASK_B)) begin
         op_class = CLS_B;
      end else if (op_match(opcode, OP_MOVZ, MASK_MOVZ)) begin
         op_class = CLS_MOVZ;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle LEGv8 control FSM with memory wait and sticky fault trap
// Defining MC_PERF_EN adds cycle_count and instr_count outputs.
module multicycle_sequencer
   import multicycle_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic        regwrite,
   output logic        memread,
   output logic        memwrite,
   output logic        branch,
   output logic        uncond_branch,
   output logic [3:0]  aluop,
   output logic [2:0]  signop,
   output logic [2:0]  state,
   output logic        fault
`ifdef MC_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
`endif
);

   state_e      state_q, state_d;
   logic [10:0] op_q, op_d;
   logic [7:0]  wait_q, wait_d;
   logic [8:0]  wait_inc;
   logic [10:0] cls_op;
   op_class_e   cls;
   logic [3:0]  ex_aluop;
   logic [2:0]  ex_signop;
   logic        ex_alusrc, ex_reg2loc;

   // One classifier: live opcode while decoding, latched opcode afterwards.
   assign cls_op   = (state_q == ST_DECODE) ? opcode : op_q;
   assign wait_inc = {1'b0, wait_q} + 9'd1;
   assign state    = state_q;

   opcode_classifier u_classifier (
      .opcode   (cls_op),
      .op_class (cls)
   );

   always_comb begin
      ex_aluop   = ALUOP_ADD;
      ex_signop  = SIGNOP_R;
      ex_alusrc  = 1'b0;
      ex_reg2loc = 1'b0;
      case (cls)
         CLS_R: begin
            if (op_q == OP_SUB)      ex_aluop = ALUOP_SUB;
            else if (op_q == OP_AND) ex_aluop = ALUOP_AND;
            else if (op_q == OP_ORR) ex_aluop = ALUOP_ORR;
         end
         CLS_LDUR: begin
            ex_signop = SIGNOP_D;
            ex_alusrc = 1'b1;
         end
         CLS_STUR: begin
            ex_signop  = SIGNOP_D;
            ex_alusrc  = 1'b1;
            ex_reg2loc = 1'b1;
         end
         CLS_CBZ: begin
            ex_aluop   = ALUOP_PASSB;
            ex_signop  = SIGNOP_CB;
            ex_reg2loc = 1'b1;
         end
         CLS_B:    ex_signop = SIGNOP_B;
         CLS_MOVZ: begin
            ex_aluop  = ALUOP_PASSB;
            ex_signop = SIGNOP_MOVZ;
            ex_alusrc = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_d        = wait_q;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg2loc       = 1'b0;
      alusrc        = 1'b0;
      mem2reg       = 1'b0;
      regwrite      = 1'b0;
      memread       = 1'b0;
      memwrite      = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      aluop         = 4'b0000;
      signop        = 3'b000;
      fault         = 1'b0;
      // ALU/extender controls stay valid from EXEC through WB so address and result remain stable.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         aluop   = ex_aluop;
         signop  = ex_signop;
         alusrc  = ex_alusrc;
         reg2loc = ex_reg2loc;
      end
      case (state_q)
         ST_FETCH: begin
            // FETCH is the reset state, so the IR load must be masked while reset is held.
            ir_write = resetl;
            state_d  = ST_DECODE;
         end
         ST_DECODE: begin
            op_d    = opcode;
            reg2loc = (cls == CLS_STUR) || (cls == CLS_CBZ);
            state_d = (cls == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
         end
         ST_EXEC: begin
            case (cls)
               CLS_R, CLS_MOVZ: state_d = ST_WB;
               CLS_LDUR, CLS_STUR: begin
                  wait_d  = 8'd0;
                  state_d = ST_MEM;
               end
               CLS_CBZ: begin
                  branch   = 1'b1;
                  pc_write = 1'b1;
                  state_d  = ST_FETCH;
               end
               CLS_B: begin
                  uncond_branch = 1'b1;
                  pc_write      = 1'b1;
                  state_d       = ST_FETCH;
               end
               default: state_d = ST_FAULT;
            endcase
         end
         ST_MEM: begin
            memread  = (cls == CLS_LDUR);
            memwrite = (cls == CLS_STUR);
            if (mem_ready) begin
               if (cls == CLS_LDUR) begin
                  state_d = ST_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else if (wait_inc >= 9'(MEM_TIMEOUT)) begin
               state_d = ST_FAULT;
            end else begin
               wait_d = wait_inc[7:0];
            end
         end
         ST_WB: begin
            regwrite = 1'b1;
            mem2reg  = (cls == CLS_LDUR);
            pc_write = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_FAULT: fault = 1'b1;
         default:  state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= ST_FETCH;
         op_q    <= 11'd0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
      end
   end

`ifdef MC_PERF_EN
   logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

   always_comb begin
      cyc_d = cyc_q + 32'd1;
      ins_d = ins_q + {31'd0, pc_write};
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         cyc_q <= 32'd0;
         ins_q <= 32'd0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   end

   assign cycle_count = cyc_q;
   assign instr_count = ins_q;
`endif

endmodule
